seg7_bcd_display: RTL
=====================

# seg7_bcd_display

Parametrised multi-digit seven-segment driver for the DE10-Lite HEX displays. A binary value is converted to BCD with a sequential shift-add-3 (double-dabble) engine, then latched into an active-low segment register. Adds leading-zero blanking, an overflow indication and a blink mode, so the parking-meter top level can drive N digits of any input width from one block.

## Interface
- WIDTH, 8, binary input width; legal range 1..30.
- DIGITS, 2, number of displayed digits; legal range 1..9.
- BLINK_DIV, 25_000_000, clock cycles per blink half-period; must be ≥ 1.
- clk  input  1  system clock; the block's only clock.
- rst_n  input  1  synchronous, active-low reset.
- value  input  WIDTH  unsigned binary value to display.
- load  input  1  one-cycle strobe that requests conversion of `value`.
- blink_en  input  1  when 1, the display blinks at the BLINK_DIV rate.
- busy  output  1  high while a conversion is in progress.
- ovf  output  1  high while the displayed value is ≥ 10**DIGITS.
- seg  output  7*DIGITS  active-low segments. Digit i occupies seg[7i+6:7i]; digit 0 is the least significant. Bit order is {g,f,e,d,c,b,a}.

## Operation
- FSM has three states: IDLE, SHIFT and LATCH. `busy` is 1 in every state except IDLE.
- **IDLE:**
  - When `load` = 1, capture `value` into the shift register.
  - Set `ovf_pend = (value >= 10**DIGITS)`.
  - Clear the BCD accumulator and set the bit counter to WIDTH.
  - Go to SHIFT.
- **SHIFT (one bit per cycle):**
  - Add 3 to every BCD nibble that is ≥ 5.
  - Then shift {bcd, bin} left by 1 and decrement the counter.
  - When the counter reaches 1, go to LATCH after that shift.
- **LATCH:**
  - Copy the lower DIGITS nibbles into the display register and copy `ovf_pend` to `ovf`.
  - Go to IDLE.
- **Accumulator size:** the internal BCD accumulator has BCD_N = (WIDTH+3)/3 nibbles, using integer division. This is enough for 2**WIDTH-1.
- **Load while busy:** `load` is ignored when the FSM is not in IDLE. There is no queueing.
- **Segment decode:**
  - 0-9 use the standard active-low patterns. Examples: 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000, 7 → 1111000.
  - Any nibble greater than 9 decodes to blank (1111111).
- **Leading-zero blanking:** a digit i > 0 is blank when it and every higher digit are 0. Digit 0 is never blanked, so value 0 shows "0".
- **Overflow:** when `ovf` = 1, every digit shows a dash (0111111). Blanking does not apply.
- **Blink:**
  - A free-running counter counts 0..BLINK_DIV-1. At the terminal count it wraps to 0 and toggles `phase`.
  - When `blink_en` = 1 and `phase` = 0, all of `seg` = 1111111.
  - When `blink_en` = 0, the display shows normally, and the counter keeps running.
- **Reset values:**
  - seg = all 1s, busy = 0, ovf = 0.
  - Display register = 0 and blank-all flag = 1, so nothing is shown until the first LATCH.
  - FSM in IDLE, blink counter = 0, phase = 1.
- **Reset mid-conversion:** the conversion is aborted and every reset value above applies on the next edge. The previously displayed value is lost.

## Timing
- Let `load` be sampled high in cycle 0, with the FSM in IDLE.
- Cycles 1..WIDTH: SHIFT, busy = 1.
- Cycle WIDTH+1: LATCH, busy = 1.
- Cycle WIDTH+2: IDLE, busy = 0. `seg` and `ovf` show the new value.
- Total latency is WIDTH+2 cycles. A new `load` is accepted in cycle WIDTH+2, so back-to-back conversions are possible.
- `seg` is combinational from registered state (display register, ovf, phase, blink_en). `blink_en` takes effect in the same cycle it changes.
- The `phase` toggle is visible on `seg` the cycle after the counter wraps.
- `value` only needs to be stable in the cycle where `load` is high.

## Structure
- **Package `seg7_pkg`:**
  - `seg7_t` (logic [6:0]).
  - Constants SEG_BLANK = 7'b1111111 and SEG_DASH = 7'b0111111.
  - Function `seg7_encode(logic [3:0])` returning `seg7_t`.
  - The FSM state enum `conv_state_t`.
- **Sub-module `bin2bcd_seq`:**
  - Contains the FSM, shift register, bit counter and overflow compare.
  - Parameters: WIDTH, DIGITS.
  - Ports: clk, rst_n, value, load, busy, bcd[4*DIGITS], ovf, done.
- **Top block:** contains the display register, blanking logic, blink counter and per-digit encoding in a generate loop.

## Test plan
All scenarios use WIDTH=8, DIGITS=3, BLINK_DIV=4 unless stated otherwise.
- **Reset:** hold rst_n = 0 for 3 cycles → seg = all 1s, busy = 0, ovf = 0. No transitions while load = 0.
- **Basic conversion:** load with value = 123 in cycle 0.
  - busy = 1 in cycles 1..9.
  - In cycle 10: digit2 = 1111001, digit1 = 0100100, digit0 = 0110000, busy = 0.
- **Leading-zero blanking:**
  - Load 7 → digit2 = digit1 = 1111111, digit0 = 1111000.
  - Load 0 → only digit0 shows 1000000.
  - Load 105 → middle digit shows 1000000.
- **Overflow (DIGITS=2):**
  - Load 200 → both digits = 0111111, ovf = 1.
  - Then load 45 → digits show 4/5, ovf = 0.
  - Boundary: 99 gives ovf = 0; 100 gives ovf = 1.
- **Load while busy / reset mid-conversion:**
  - Load 50, then load 99 in cycle 3 → display shows 50 in cycle 10. A second load in cycle 10 is accepted.
  - Load 123, drop rst_n in cycle 5 → all-blank display, busy = 0 on the next edge.
- **Blink:** display 42 and set blink_en = 1.
  - seg alternates between value and all 1s every 4 cycles.
  - Clearing blink_en during the off phase shows 42 in the same cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// seg7_pkg : segment types, constants, digit encoder and FSM state enum
// rev 1.0
// ----------------------------------------------------------------------
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } conv_state_t;

  // Active-low {g,f,e,d,c,b,a}; anything above 9 is blank
  function automatic seg7_t seg7_encode(input logic [3:0] nib);
    case (nib)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ----------------------------------------------------------------------
// bin2bcd_seq : sequential double-dabble converter with overflow flag
// rev 1.0
// ----------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    value,
  input  logic                load,
  output logic                busy,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf,
  output logic                done
);
  import seg7_pkg::*;

  localparam int BCD_N = (WIDTH + 3) / 3;
  // Never narrower than the display so short inputs still fill every digit
  localparam int ACC_N = (BCD_N > DIGITS) ? BCD_N : DIGITS;
  localparam int ACC_W = 4 * ACC_N;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [63:0] c_limit = pow10(DIGITS);

  conv_state_t      r_state, w_state_next;
  logic [WIDTH-1:0] r_bin;
  logic [ACC_W-1:0] r_bcd, w_adj;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_pend, r_ovf;
  logic             w_ovf_cmp;
  logic             w_unused;

  assign w_ovf_cmp = (64'(value) >= c_limit);

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < ACC_N; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (load) w_state_next = SHIFT;
      SHIFT:   if (r_cnt == CNT_W'(1)) w_state_next = LATCH;
      LATCH:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_bin      <= value;
            r_bcd      <= '0;
            r_cnt      <= CNT_W'(WIDTH);
            r_ovf_pend <= w_ovf_cmp;
          end
        end
        SHIFT: begin
          r_bcd <= {w_adj[ACC_W-2:0], r_bin[WIDTH-1]};
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        LATCH:   r_ovf <= r_ovf_pend;
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == LATCH);
  assign bcd  = r_bcd[4*DIGITS-1:0];
  assign ovf  = r_ovf;

  // Nibbles above the display and the carry out of the top nibble are don't-care
  if (ACC_N > DIGITS) begin : g_spare
    assign w_unused = w_adj[ACC_W-1] ^ (^r_bcd[ACC_W-1:4*DIGITS]);
  end else begin : g_nospare
    assign w_unused = w_adj[ACC_W-1];
  end

endmodule
`default_nettype wire

// File: rtl/seg7_bcd_display.sv
`default_nettype none
// ----------------------------------------------------------------------
// seg7_bcd_display : N-digit seven-segment driver with blanking and blink
// rev 1.0
// ----------------------------------------------------------------------
module seg7_bcd_display #(
  parameter int WIDTH     = 8,
  parameter int DIGITS    = 2,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    value,
  input  logic                load,
  input  logic                blink_en,
  output logic                busy,
  output logic                ovf,
  output logic [7*DIGITS-1:0] seg
);
  import seg7_pkg::*;

  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [BW-1:0] c_blink_term = BW'(BLINK_DIV - 1);

  logic [4*DIGITS-1:0] w_bcd, r_disp;
  logic                w_done, r_blank_all;
  logic [BW-1:0]       r_blink_cnt;
  logic                r_phase, w_blink_off;
  logic [DIGITS-1:0]   w_upper_nz;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .load  (load),
    .busy  (busy),
    .bcd   (w_bcd),
    .ovf   (ovf),
    .done  (w_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disp      <= '0;
      r_blank_all <= 1'b1;
    end else if (w_done) begin
      r_disp      <= w_bcd;
      r_blank_all <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_blink_cnt == c_blink_term) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  assign w_blink_off = blink_en & ~r_phase;

  // w_upper_nz[i]: digit i or some digit above it is non-zero
  always_comb begin
    logic acc;
    acc        = 1'b0;
    w_upper_nz = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc           = acc | (r_disp[4*i +: 4] != 4'd0);
      w_upper_nz[i] = acc;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic w_lead_blank;
    if (i == 0) begin : g_lsd
      assign w_lead_blank = 1'b0;
    end else begin : g_upper
      assign w_lead_blank = ~w_upper_nz[i];
    end
    assign seg[7*i +: 7] = (w_blink_off || r_blank_all) ? SEG_BLANK :
                           ovf                          ? SEG_DASH  :
                           w_lead_blank                 ? SEG_BLANK :
                           seg7_encode(r_disp[4*i +: 4]);
  end

endmodule
`default_nettype wire
